// File: rtl/serial_capture_unit.sv
// Receiving end of the register-pair serial link: strobes WIDTH shifts, rebuilds
// both LSB-first operands and forms a per-bit bitwise function of them.
module serial_capture_unit #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       F,
  input  logic             A_Serial,
  input  logic             B_Serial,
  output logic             Shift_En,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] A_Cap,
  output logic [WIDTH-1:0] B_Cap,
  output logic [WIDTH-1:0] Result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f_reg;

  function automatic logic bit_op(input logic [2:0] sel, input logic a, input logic b);
    logic r;
    case (sel)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = 1'b1;
      3'b100:  r = ~(a & b);
      3'b101:  r = ~(a | b);
      3'b110:  r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_next = state;
    Shift_En   = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_next = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
        if (cnt == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        Done = 1'b1;
        // A held Start must not retrigger; only a released Start re-arms.
        if (!Start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      f_reg  <= 3'b000;
      A_Cap  <= '0;
      B_Cap  <= '0;
      Result <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (Start) begin
            f_reg  <= F;
            cnt    <= '0;
            A_Cap  <= '0;
            B_Cap  <= '0;
            Result <= '0;
          end
        end
        SHIFT: begin
          // Source shifts on this same edge, so its current LSB is sampled here.
          A_Cap  <= {A_Serial, A_Cap[WIDTH-1:1]};
          B_Cap  <= {B_Serial, B_Cap[WIDTH-1:1]};
          Result <= {bit_op(f_reg, A_Serial, B_Serial), Result[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_capture_unit.sv
// Directed bench for serial_capture_unit; the bench plays the operand register
// pair, presenting the current LSB and shifting whenever Shift_En is seen.
module tb_serial_capture_unit;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [2:0] F;
  logic       A_Serial;
  logic       B_Serial;
  logic       Shift_En;
  logic       Busy;
  logic       Done;
  logic [7:0] A_Cap;
  logic [7:0] B_Cap;
  logic [7:0] Result;

  int checks   = 0;
  int failures = 0;

  serial_capture_unit #(.WIDTH(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .F        (F),
    .A_Serial (A_Serial),
    .B_Serial (B_Serial),
    .Shift_En (Shift_En),
    .Busy     (Busy),
    .Done     (Done),
    .A_Cap    (A_Cap),
    .B_Cap    (B_Cap),
    .Result   (Result)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer with Start held. f2 is applied once shifts==f2_at (if >=0);
  // Reset is raised (and Start dropped) once shifts==rst_at (if >=0).
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f,
                     input logic [2:0] f2, input int f2_at, input int rst_at,
                     output int shifts, output bit done_seen, output bit busy_ok);
    logic [7:0] src_a, src_b;
    src_a = a;
    src_b = b;
    shifts = 0;
    done_seen = 0;
    busy_ok = 1;
    @(negedge Clk);
    Start = 1'b1;
    F = f;
    A_Serial = src_a[0];
    B_Serial = src_b[0];
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (Done) begin
        done_seen = 1;
        break;
      end
      if (rst_at >= 0 && shifts == rst_at) begin
        Reset = 1'b1;
        Start = 1'b0;
        break;
      end
      if (f2_at >= 0 && shifts == f2_at) F = f2;
      if (Busy !== Shift_En) busy_ok = 0;
      A_Serial = src_a[0];
      B_Serial = src_b[0];
      if (Shift_En) begin
        shifts++;
        src_a = src_a >> 1;
        src_b = src_b >> 1;
      end
    end
  endtask

  task automatic release_start();
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    int  shifts;
    bit  done_seen;
    bit  busy_ok;
    int  extra;
    bit  done_held;

    Reset = 1'b1;
    Start = 1'b0;
    F = 3'b000;
    A_Serial = 1'b0;
    B_Serial = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_shift_en", Shift_En, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_a_cap", A_Cap, 8'h00);
    check("rst_b_cap", B_Cap, 8'h00);
    check("rst_result", Result, 8'h00);
    Reset = 1'b0;

    // Test 1: AND, Start held past completion.
    run(8'h33, 8'h55, 3'b000, 3'b000, -1, -1, shifts, done_seen, busy_ok);
    check("t1_shifts", shifts, 8);
    check("t1_done", done_seen, 1);
    check("t1_busy", busy_ok, 1);
    check("t1_a_cap", A_Cap, 8'h33);
    check("t1_b_cap", B_Cap, 8'h55);
    check("t1_result", Result, 8'h11);
    repeat (3) @(negedge Clk);
    check("t1_done_hold", Done, 1);
    check("t1_no_shift", Shift_En, 0);
    release_start();
    check("t1_idle_done", Done, 0);
    check("t1_result_kept", Result, 8'h11);

    // Test 2: XOR then XNOR.
    run(8'h33, 8'h55, 3'b010, 3'b010, -1, -1, shifts, done_seen, busy_ok);
    check("t2x_shifts", shifts, 8);
    check("t2x_a_cap", A_Cap, 8'h33);
    check("t2x_b_cap", B_Cap, 8'h55);
    check("t2x_result", Result, 8'h66);
    release_start();
    run(8'h33, 8'h55, 3'b110, 3'b110, -1, -1, shifts, done_seen, busy_ok);
    check("t2n_a_cap", A_Cap, 8'h33);
    check("t2n_b_cap", B_Cap, 8'h55);
    check("t2n_result", Result, 8'h99);
    release_start();

    // Test 3: NOR, constant 1, constant 0.
    run(8'hF0, 8'h0F, 3'b101, 3'b101, -1, -1, shifts, done_seen, busy_ok);
    check("t3_nor", Result, 8'h00);
    check("t3_nor_a_cap", A_Cap, 8'hF0);
    release_start();
    run(8'hF0, 8'h0F, 3'b011, 3'b011, -1, -1, shifts, done_seen, busy_ok);
    check("t3_one", Result, 8'hFF);
    release_start();
    run(8'hF0, 8'h0F, 3'b111, 3'b111, -1, -1, shifts, done_seen, busy_ok);
    check("t3_zero", Result, 8'h00);
    check("t3_zero_b_cap", B_Cap, 8'h0F);
    release_start();

    // Extra patterns: OR and NAND.
    run(8'h3C, 8'hA5, 3'b001, 3'b001, -1, -1, shifts, done_seen, busy_ok);
    check("or_result", Result, 8'hBD);
    release_start();
    run(8'hC3, 8'h96, 3'b100, 3'b100, -1, -1, shifts, done_seen, busy_ok);
    check("nand_result", Result, 8'h7D);
    release_start();

    // Test 4: F changes to OR during the 3rd shift cycle; ignored.
    run(8'hAA, 8'h0F, 3'b000, 3'b001, 2, -1, shifts, done_seen, busy_ok);
    check("t4_shifts", shifts, 8);
    check("t4_result", Result, 8'h0A);
    release_start();

    // Test 5: Reset during the 4th shift cycle.
    run(8'h33, 8'h55, 3'b001, 3'b001, -1, 3, shifts, done_seen, busy_ok);
    check("t5_shifts_before", shifts, 3);
    @(negedge Clk);
    check("t5_shift_en", Shift_En, 0);
    check("t5_busy", Busy, 0);
    check("t5_done", Done, 0);
    check("t5_a_cap", A_Cap, 8'h00);
    check("t5_b_cap", B_Cap, 8'h00);
    check("t5_result", Result, 8'h00);
    Reset = 1'b0;
    run(8'h33, 8'h55, 3'b000, 3'b000, -1, -1, shifts, done_seen, busy_ok);
    check("t5_after_shifts", shifts, 8);
    check("t5_after_result", Result, 8'h11);

    // Test 6: Start held across DONE for 20 cycles, no retrigger.
    extra = 0;
    done_held = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (Shift_En) extra++;
      if (!Done) done_held = 0;
    end
    check("t6_no_burst", extra, 0);
    check("t6_done_held", done_held, 1);
    release_start();
    check("t6_idle", Done, 0);
    run(8'h5A, 8'hFF, 3'b010, 3'b010, -1, -1, shifts, done_seen, busy_ok);
    check("t6_burst", shifts, 8);
    check("t6_done", done_seen, 1);
    check("t6_result", Result, 8'hA5);
    release_start();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
